// File: rtl/alu_cmp_unit_pkg.sv
// Shared encodings for the EXE-stage ALU (MIPS funct codes) and the branch comparator
// (primary opcodes and REGIMM rt selectors).
package alu_cmp_unit_pkg;

  typedef enum logic [5:0] {
    ALU_SLL   = 6'h00,
    ALU_SRL   = 6'h02,
    ALU_SRA   = 6'h03,
    ALU_SLLV  = 6'h04,
    ALU_SRLV  = 6'h06,
    ALU_SRAV  = 6'h07,
    ALU_LUI   = 6'h0F,
    ALU_MFHI  = 6'h10,
    ALU_MTHI  = 6'h11,
    ALU_MFLO  = 6'h12,
    ALU_MTLO  = 6'h13,
    ALU_MULT  = 6'h18,
    ALU_MULTU = 6'h19,
    ALU_DIV   = 6'h1A,
    ALU_DIVU  = 6'h1B,
    ALU_ADD   = 6'h20,
    ALU_ADDU  = 6'h21,
    ALU_SUB   = 6'h22,
    ALU_SUBU  = 6'h23,
    ALU_AND   = 6'h24,
    ALU_OR    = 6'h25,
    ALU_XOR   = 6'h26,
    ALU_NOR   = 6'h27,
    ALU_SLT   = 6'h2A,
    ALU_SLTU  = 6'h2B
  } alu_op_e;

  localparam logic [5:0] OPC_REGIMM = 6'd1;
  localparam logic [5:0] OPC_BEQ    = 6'd4;
  localparam logic [5:0] OPC_BNE    = 6'd5;
  localparam logic [5:0] OPC_BLEZ   = 6'd6;
  localparam logic [5:0] OPC_BGTZ   = 6'd7;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

endpackage

// File: rtl/alu_cmp_unit_alu_core.sv
// Combinational 32-bit ALU with HI/LO registers written by MT*/MULT*/DIV* on the rising edge.
// alu_result has zero latency; HI/LO results are visible the cycle after the op.
module alu_cmp_unit_alu_core
  import alu_cmp_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [5:0]  alu_op_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  alu_op_e     op;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result;

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] divisor;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [31:0] sra_imm, sra_var;

  assign op = alu_op_e'(alu_op_i);

  assign prod_s = $signed({{32{op_a_i[31]}}, op_a_i}) * $signed({{32{op_b_i[31]}}, op_b_i});
  assign prod_u = {32'd0, op_a_i} * {32'd0, op_b_i};

  // Divide by a harmless 1 when b==0 so the dividers never produce X; the write is suppressed anyway.
  assign div_zero = (op_b_i == 32'd0);
  assign divisor  = div_zero ? 32'd1 : op_b_i;
  assign quot_s   = $signed(op_a_i) / $signed(divisor);
  assign rem_s    = $signed(op_a_i) % $signed(divisor);
  assign quot_u   = op_a_i / divisor;
  assign rem_u    = op_a_i % divisor;

  assign sra_imm  = $signed(op_b_i) >>> shamt_i;
  assign sra_var  = $signed(op_b_i) >>> op_a_i[4:0];

  always_comb begin
    result = 32'd0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (op)
      ALU_ADD, ALU_ADDU: result = op_a_i + op_b_i;
      ALU_SUB, ALU_SUBU: result = op_a_i - op_b_i;
      ALU_AND:   result = op_a_i & op_b_i;
      ALU_OR:    result = op_a_i | op_b_i;
      ALU_XOR:   result = op_a_i ^ op_b_i;
      ALU_NOR:   result = ~(op_a_i | op_b_i);
      ALU_SLT:   result = {31'd0, $signed(op_a_i) < $signed(op_b_i)};
      ALU_SLTU:  result = {31'd0, op_a_i < op_b_i};
      ALU_SLL:   result = op_b_i << shamt_i;
      ALU_SRL:   result = op_b_i >> shamt_i;
      ALU_SRA:   result = sra_imm;
      ALU_SLLV:  result = op_b_i << op_a_i[4:0];
      ALU_SRLV:  result = op_b_i >> op_a_i[4:0];
      ALU_SRAV:  result = sra_var;
      ALU_LUI:   result = {op_b_i[15:0], 16'h0000};
      ALU_MFHI:  result = hi_q;
      ALU_MFLO:  result = lo_q;
      ALU_MTHI:  hi_d = op_a_i;
      ALU_MTLO:  lo_d = op_a_i;
      ALU_MULT:  {hi_d, lo_d} = prod_s;
      ALU_MULTU: {hi_d, lo_d} = prod_u;
      ALU_DIV: begin
        if (!div_zero) begin
          lo_d = quot_s;
          hi_d = rem_s;
        end
      end
      ALU_DIVU: begin
        if (!div_zero) begin
          lo_d = quot_u;
          hi_d = rem_u;
        end
      end
      default: result = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign result_o = result;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: rtl/alu_cmp_unit_branch_cmp.sv
// Branch-condition comparator: decodes opcode/rt from the instruction word, zero-latency.
// Unknown opcodes and REGIMM selectors resolve to not-taken unless forced.
module alu_cmp_unit_branch_cmp
  import alu_cmp_unit_pkg::*;
(
  input  logic        force_taken_i,
  input  logic [31:0] cmp_a_i,
  input  logic [31:0] cmp_b_i,
  input  logic [31:0] instr_i,
  output logic        taken_o
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic       a_neg, a_zero, cond;
  logic       unused_instr_bits;

  assign opcode = instr_i[31:26];
  assign rt     = instr_i[20:16];
  assign unused_instr_bits = ^{instr_i[25:21], instr_i[15:0]};

  assign a_neg  = cmp_a_i[31];
  assign a_zero = (cmp_a_i == 32'd0);

  always_comb begin
    cond = 1'b0;
    case (opcode)
      OPC_BEQ:  cond = (cmp_a_i == cmp_b_i);
      OPC_BNE:  cond = (cmp_a_i != cmp_b_i);
      OPC_BLEZ: cond = a_neg | a_zero;
      OPC_BGTZ: cond = ~a_neg & ~a_zero;
      OPC_REGIMM: begin
        // The link variants share the condition of their plain forms.
        case (rt)
          RT_BLTZ, RT_BLTZAL: cond = a_neg;
          RT_BGEZ, RT_BGEZAL: cond = ~a_neg;
          default:            cond = 1'b0;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = force_taken_i | cond;

endmodule

// File: rtl/alu_cmp_unit.sv
// EXE-stage integer datapath: ALU with HI/LO registers plus branch comparator.
// alu_result and taken are combinational; HI/LO update on the rising CLK edge.
module alu_cmp_unit
  import alu_cmp_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  alu_op,
  input  logic [4:0]  shamt,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  input  logic        force_taken,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  input  logic [31:0] instr,
  output logic        taken
);

  alu_cmp_unit_alu_core u_alu_core (
    .clk_i    (CLK),
    .rst_n_i  (RESET),
    .alu_op_i (alu_op),
    .shamt_i  (shamt),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .result_o (alu_result),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  alu_cmp_unit_branch_cmp u_branch_cmp (
    .force_taken_i (force_taken),
    .cmp_a_i       (cmp_a),
    .cmp_b_i       (cmp_b),
    .instr_i       (instr),
    .taken_o       (taken)
  );

endmodule

// File: tb/tb_alu_cmp_unit.sv
// Directed bench for alu_cmp_unit: stimulus pushes expected outputs into a scoreboard,
// a separate monitor pops and compares them on each sample strobe.
module tb_alu_cmp_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [5:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_result, hi, lo;
  logic        force_taken;
  logic [31:0] cmp_a, cmp_b, instr;
  logic        taken;

  localparam int S_RES = 0, S_HI = 1, S_LO = 2, S_TKN = 3;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  alu_cmp_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .alu_op      (alu_op),
    .shamt       (shamt),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_result  (alu_result),
    .hi          (hi),
    .lo          (lo),
    .force_taken (force_taken),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .instr       (instr),
    .taken       (taken)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_RES:   return alu_result;
      S_HI:    return hi;
      S_LO:    return lo;
      default: return {31'd0, taken};
    endcase
  endfunction

  // Monitor: drains every queued expectation when the stimulus strobes a sample point.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = observe(e.sel);
        checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
      end
    end
  end

  // Watchdog: a run that outlives its budget counts as a failure.
  initial begin
    #100000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic check_now(input logic [31:0] got, input logic [31:0] exp_v, input string n);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp_v);
    end
  endtask

  task automatic expect_out(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu(input logic [5:0] op, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    shamt  = sh;
    op_a   = a;
    op_b   = b;
  endtask

  task automatic br(input logic frc, input logic [5:0] opc, input logic [4:0] rt,
                    input logic [31:0] a, input logic [31:0] b);
    force_taken = frc;
    instr       = {opc, 5'd3, rt, 16'h1234};
    cmp_a       = a;
    cmp_b       = b;
  endtask

  task automatic alu_chk(input logic [5:0] op, input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_v, input string n);
    alu(op, sh, a, b);
    expect_out(S_RES, exp_v, n);
    sample();
  endtask

  task automatic br_chk(input logic frc, input logic [5:0] opc, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b, input logic exp_t_,
                        input string n);
    br(frc, opc, rt, a, b);
    expect_out(S_TKN, {31'd0, exp_t_}, n);
    sample();
  endtask

  task automatic hilo_chk(input logic [31:0] eh, input logic [31:0] el, input string n);
    expect_out(S_HI, eh, {n, "_hi"});
    expect_out(S_LO, el, {n, "_lo"});
    sample();
  endtask

  initial begin
    RESET = 1'b0;
    alu(6'h21, 5'd0, 32'd0, 32'd0);
    br(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    #3;
    check_now(hi, 32'd0, "reset_hi");
    check_now(lo, 32'd0, "reset_lo");
    cyc();
    RESET = 1'b1;

    // Combinational ALU vectors
    alu_chk(6'h20, 5'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, "add_ovf");
    alu_chk(6'h23, 5'd0, 32'h0,        32'h1,        32'hFFFFFFFF, "subu_wrap");
    alu_chk(6'h22, 5'd0, 32'd10,       32'd3,        32'd7,        "sub");
    alu_chk(6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        32'd1,        "slt_neg");
    alu_chk(6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1,        32'd0,        "sltu_big");
    alu_chk(6'h03, 5'd4, 32'h0,        32'h80000000, 32'hF8000000, "sra");
    alu_chk(6'h02, 5'd4, 32'h0,        32'h80000000, 32'h08000000, "srl");
    alu_chk(6'h00, 5'd8, 32'h0,        32'h000000A5, 32'h0000A500, "sll");
    alu_chk(6'h06, 5'd0, 32'd4,        32'h80000000, 32'h08000000, "srlv");
    alu_chk(6'h07, 5'd0, 32'h24,       32'h80000000, 32'hF8000000, "srav_a4_0");
    alu_chk(6'h04, 5'd0, 32'd1,        32'h40000001, 32'h80000002, "sllv");
    alu_chk(6'h0F, 5'd0, 32'h0,        32'h00001234, 32'h12340000, "lui");
    alu_chk(6'h24, 5'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, "and");
    alu_chk(6'h25, 5'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, "or");
    alu_chk(6'h26, 5'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0, "xor");
    alu_chk(6'h27, 5'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h000F000F, "nor");
    alu_chk(6'h3F, 5'd0, 32'h12345678, 32'h1,        32'd0,        "undef_op");
    alu_chk(6'h20, 5'd0, 32'h00400010, 32'hFFFFFFF0, 32'h00400000, "br_target");
    alu_op = 6'h21;
    cyc();

    // Multiply: result visible only after the edge
    alu_chk(6'h18, 5'd0, 32'hFFFFFFFE, 32'd3, 32'd0, "mult_res");
    hilo_chk(32'd0, 32'd0, "mult_same_cycle");
    cyc();
    alu_chk(6'h12, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFA, "mflo_after_mult");
    hilo_chk(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    alu(6'h19, 5'd0, 32'hFFFFFFFF, 32'd2);
    cyc();
    hilo_chk(32'h00000001, 32'hFFFFFFFE, "multu");

    // Divide
    alu(6'h1A, 5'd0, 32'd7, 32'hFFFFFFFE);
    cyc();
    hilo_chk(32'd1, 32'hFFFFFFFD, "div_7_m2");
    alu_chk(6'h10, 5'd0, 32'd0, 32'd0, 32'd1, "mfhi_after_div");
    alu(6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2);
    cyc();
    hilo_chk(32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    alu(6'h1B, 5'd0, 32'd9, 32'd0);
    cyc();
    hilo_chk(32'hFFFFFFFF, 32'hFFFFFFFD, "divu_zero");
    alu(6'h1B, 5'd0, 32'hFFFFFFF9, 32'd2);
    cyc();
    hilo_chk(32'd1, 32'h7FFFFFFC, "divu");
    alu(6'h13, 5'd0, 32'h000000AB, 32'd0);
    cyc();
    hilo_chk(32'd1, 32'h000000AB, "mtlo");

    // Asynchronous reset between edges
    alu(6'h11, 5'd0, 32'd5, 32'd0);
    cyc();
    alu(6'h21, 5'd0, 32'd0, 32'd0);
    hilo_chk(32'd5, 32'h000000AB, "mthi");
    RESET = 1'b0;
    #1;
    check_now(hi, 32'd0, "async_reset_hi");
    check_now(lo, 32'd0, "async_reset_lo");
    RESET = 1'b1;

    // Frozen pipeline: MTHI held across three edges
    alu(6'h11, 5'd0, 32'd5, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out(S_HI, 32'd5, "mthi_hold");
      sample();
    end
    alu(6'h21, 5'd0, 32'd0, 32'd0);

    // Branch comparator
    br_chk(1'b0, 6'd4, 5'd0,    32'd9,        32'd9, 1'b1, "beq_eq");
    br_chk(1'b0, 6'd4, 5'd0,    32'd9,        32'd8, 1'b0, "beq_ne");
    br_chk(1'b0, 6'd5, 5'd0,    32'd9,        32'd9, 1'b0, "bne_eq");
    br_chk(1'b0, 6'd5, 5'd0,    32'd9,        32'd8, 1'b1, "bne_ne");
    br_chk(1'b0, 6'd6, 5'd0,    32'd0,        32'd0, 1'b1, "blez_0");
    br_chk(1'b0, 6'd6, 5'd0,    32'd1,        32'd0, 1'b0, "blez_pos");
    br_chk(1'b0, 6'd7, 5'd0,    32'd0,        32'd0, 1'b0, "bgtz_0");
    br_chk(1'b0, 6'd7, 5'd0,    32'd5,        32'd0, 1'b1, "bgtz_pos");
    br_chk(1'b0, 6'd7, 5'd0,    32'h80000000, 32'd0, 1'b0, "bgtz_min");
    br_chk(1'b0, 6'd1, 5'h00,   32'hFFFFFFFF, 32'd0, 1'b1, "bltz_neg");
    br_chk(1'b0, 6'd1, 5'h01,   32'hFFFFFFFF, 32'd0, 1'b0, "bgez_neg");
    br_chk(1'b0, 6'd1, 5'h01,   32'd0,        32'd0, 1'b1, "bgez_0");
    br_chk(1'b0, 6'd1, 5'h10,   32'hFFFFFFFF, 32'd0, 1'b1, "bltzal_neg");
    br_chk(1'b0, 6'd1, 5'h11,   32'd3,        32'd0, 1'b1, "bgezal_pos");
    br_chk(1'b0, 6'd1, 5'h02,   32'hFFFFFFFF, 32'd0, 1'b0, "regimm_other");
    br_chk(1'b0, 6'h23, 5'd0,   32'd9,        32'd9, 1'b0, "lw_op");
    br_chk(1'b1, 6'h23, 5'd0,   32'd9,        32'd9, 1'b1, "force_taken");

    cyc();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmp_unit.md
# alu_cmp_unit

Integer execute datapath for the single-issue MIPS-style EXE stage: a combinational 32-bit ALU with clocked HI/LO multiply/divide registers, plus a combinational branch-condition comparator. EXE drives operands after forwarding and registers the results into its pipeline latch. Branch target arithmetic also goes through the ALU: EXE supplies PC and imm<<2 with the ADD code.

## Interface
- No parameters.
- CLK  in  1  clock; HI/LO update on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- alu_op  in  6  ALU control code; values defined in Operation.
- shamt  in  5  shift amount for SLL/SRL/SRA (Instr[10:6]).
- op_a  in  32  ALU operand 1 (rs value or PC).
- op_b  in  32  ALU operand 2 (rt value, immediate, or imm<<2).
- alu_result  out  32  combinational ALU result.
- hi  out  32  HI register.
- lo  out  32  LO register.
- force_taken  in  1  1 = taken regardless of condition; EXE ties it to 0.
- cmp_a  in  32  branch rs value.
- cmp_b  in  32  branch rt value.
- instr  in  32  instruction word being executed.
- taken  out  1  combinational branch-taken decision.

## Operation
- ALU codes are MIPS funct values.
- 0x20 ADD and 0x21 ADDU: a+b, modulo 2^32, no overflow trap.
- 0x22 SUB and 0x23 SUBU: a−b, modulo 2^32.
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
- 0x2A SLT: signed a<b → 1, else 0.
- 0x2B SLTU: unsigned a<b → 1, else 0.
- 0x00 SLL: b<<shamt.
- 0x02 SRL: b>>shamt, logical.
- 0x03 SRA: b>>>shamt, arithmetic.
- 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: shift b by a[4:0].
- 0x0F LUI: {b[15:0],16'h0}.
- 0x10 MFHI: result = hi. 0x12 MFLO: result = lo.
- 0x11 MTHI: hi←a. 0x13 MTLO: lo←a.
- 0x18 MULT: signed 64-bit product; {hi,lo}←product.
- 0x19 MULTU: same, unsigned.
- 0x1A DIV: signed; lo←quotient, hi←remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- 0x1B DIVU: same, unsigned.
- DIV/DIVU with b=0: HI and LO unchanged.
- alu_result is 0 for MULT/DIV/MT* and for any undefined code.
- Comparator: opcode = instr[31:26], rt = instr[20:16].
  - opcode 4 BEQ: a==b.
  - opcode 5 BNE: a!=b.
  - opcode 6 BLEZ: signed a<=0.
  - opcode 7 BGTZ: signed a>0.
  - opcode 1 (REGIMM): rt 0x00 or 0x10 → signed a<0; rt 0x01 or 0x11 → signed a>=0; other rt → 0.
  - Any other opcode → taken=0.
  - force_taken=1 → taken=1.

## Timing
- alu_result and taken are purely combinational, with zero-cycle latency.
- HI/LO change only at a rising CLK edge while alu_op is MT*/MULT*/DIV*.
- MFHI/MFLO read the current registers. An MFHI in the cycle after MULT sees the new value; in the same cycle it sees the old one.
- Repeated edges with the same op and operands (frozen pipeline) rewrite identical values, so stalls are harmless.
- Reset: hi=0 and lo=0 immediately on RESET low, independent of CLK. Reset mid-operation discards any pending write.
- Multiply/divide complete in one cycle: combinational operator, result registered.

## Structure
- Shared package holds the ALU code constants and the opcode/REGIMM-rt constants.
- Natural sub-modules:
  - alu_core: combinational datapath plus HI/LO registers.
  - branch_cmp: comparator.
- alu_cmp_unit instantiates both.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000. SUBU 0−1 → 0xFFFFFFFF. SLT −1 vs 1 → 1; SLTU same operands → 0.
- SRA b=0x80000000, shamt=4 → 0xF8000000. SRLV a=4 → 0x08000000. LUI b=0x1234 → 0x12340000.
- MULT −2×3, clock edge → hi=0xFFFFFFFF, lo=0xFFFFFFFA. Next cycle MFLO → 0xFFFFFFFA. DIV 7/−2 → lo=0xFFFFFFFD, hi=1. DIVU by 0 → hi/lo unchanged.
- Assert RESET low between edges after MTHI a=5 → hi=0 immediately. Hold alu_op=MTHI across 3 edges → hi stays 5.
- Branches:
  - BEQ a=b=9 → 1. BNE same → 0.
  - BLEZ a=0 → 1. BGTZ a=0 → 0.
  - BLTZ a=−1 → 1. BGEZ a=−1 → 0.
  - opcode 0x23 (LW) → 0. force_taken=1 with opcode 0x23 → 1.
- Branch target: ADD with a=0x00400010, b=0xFFFFFFF0 → 0x00400000.
